// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multi-cycle 16-bit datapath: steps each
// instruction through fetch/decode/execute/memory/writeback and drives every select.
module multicycle_control_fsm #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [3:0]       opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSource,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             Halted,
    output logic             Illegal,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] RetiredCount
);
    // state    | meaning
    // IDLE     | waiting for Run
    // FETCH    | IR <= mem[PC], PC <= PC+2
    // DECODE   | branch target into ALUOut, dispatch on opcode
    // R_EXEC   | ALU on two registers using funct
    // R_WB     | write rd
    // I_EXEC   | ALU on register and imm8
    // I_WB     | write rt
    // MEM_ADDR | effective address for LW/SW
    // MEM_RD   | read strobe until MemReady
    // LW_WB    | write MDR into rt
    // MEM_WR   | write strobe until MemReady
    // BRANCH   | compare, conditional PC load
    // HALT     | stopped until Reset
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB,
        MEM_ADDR, MEM_RD, LW_WB, MEM_WR, BRANCH, HALT
    } state_e;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1100;
    localparam logic [3:0] OP_BEQ  = 4'b0010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   ret_q, ret_d;
    logic               ill_q, ill_d;
    logic               to_q, to_d;
    logic               retire;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            ret_q   <= '0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ret_q   <= ret_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        ill_d   = ill_q;
        to_d    = to_q;
        retire  = 1'b0;
        case (state_q)
            IDLE:     if (Run) state_d = FETCH;
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:         state_d = R_EXEC;
                    OP_ADDI:      state_d = I_EXEC;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_HALT:      state_d = HALT;
                    default: begin
                        state_d = HALT;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            R_EXEC:   state_d = R_WB;
            I_EXEC:   state_d = I_WB;
            MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD, MEM_WR: begin
                // A completing access beats the timeout in the same cycle
                if (MemReady) begin
                    if (state_q == MEM_RD) begin
                        state_d = LW_WB;
                    end else begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = HALT;
                    to_d    = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            R_WB, I_WB, LW_WB, BRANCH: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            HALT:     state_d = HALT;
            default:  state_d = IDLE;
        endcase
        ret_d = retire ? ret_q + CNT_W'(1) : ret_q;
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        MemToReg    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        Halted      = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            DECODE:   ALUSrcB = 2'b11;
            R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            I_EXEC, MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            I_WB:     RegWrite = 1'b1;
            MEM_RD:   MemRead = 1'b1;
            LW_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            MEM_WR:   MemWrite = 1'b1;
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            HALT:     Halted = 1'b1;
            default: ;
        endcase
    end

    assign Illegal      = ill_q;
    assign MemTimeout   = to_q;
    assign RetiredCount = ret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: expected per-cycle control vectors go
// into a scoreboard queue, a negedge monitor pops and compares them.
module tb_multicycle_control_fsm;
    localparam int CW = 8;   // narrow counter so the wrap is reachable in a short run
    localparam int VW = 17 + CW;

    typedef enum int {
        T_IDLE, T_FETCH, T_DECODE, T_R_EXEC, T_R_WB, T_I_EXEC, T_I_WB,
        T_MEM_ADDR, T_MEM_RD, T_LW_WB, T_MEM_WR, T_BRANCH, T_HALT
    } tst_e;

    typedef struct {
        logic [VW-1:0] v;
        int            n;
    } sb_t;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Run = 1'b0;
    logic [3:0]    opcode = 4'b0000;
    logic          MemReady = 1'b0;
    logic          PCWrite, PCWriteCond, PCSource, IRWrite, RegDst, RegWrite;
    logic          MemToReg, MemRead, MemWrite, ALUSrcA, Halted, Illegal, MemTimeout;
    logic [1:0]    ALUSrcB, ALUOp;
    logic [CW-1:0] RetiredCount;

    multicycle_control_fsm #(.MAX_WAIT(15), .CNT_W(CW)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .opcode(opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .Halted(Halted), .Illegal(Illegal), .MemTimeout(MemTimeout),
        .RetiredCount(RetiredCount)
    );

    always #5 Clock = ~Clock;

    int            n_chk = 0;
    int            n_fail = 0;
    int            n_step = 0;
    sb_t           sb[$];
    tst_e          prev_s = T_IDLE;
    logic [CW-1:0] exp_ret = '0;
    logic          exp_ill = 1'b0;
    logic          exp_to = 1'b0;

    wire [VW-1:0] act = {PCWrite, PCWriteCond, PCSource, IRWrite, RegDst, RegWrite,
                         MemToReg, MemRead, MemWrite, ALUSrcA, ALUSrcB, ALUOp,
                         Halted, Illegal, MemTimeout, RetiredCount};

    // Hand-written control table; field order matches act
    function automatic logic [VW-1:0] exp_vec(tst_e s);
        logic pcw, pcc, pcs, irw, rd, rw, m2r, mr, mw, asa, hlt;
        logic [1:0] asb, aop;
        {pcw, pcc, pcs, irw, rd, rw, m2r, mr, mw, asa, hlt} = '0;
        asb = 2'b00;
        aop = 2'b00;
        case (s)
            T_FETCH:    begin irw = 1; pcw = 1; asb = 2'b01; end
            T_DECODE:   asb = 2'b11;
            T_R_EXEC:   begin asa = 1; aop = 2'b10; end
            T_R_WB:     begin rd = 1; rw = 1; end
            T_I_EXEC:   begin asa = 1; asb = 2'b10; end
            T_I_WB:     rw = 1;
            T_MEM_ADDR: begin asa = 1; asb = 2'b10; end
            T_MEM_RD:   mr = 1;
            T_LW_WB:    begin rw = 1; m2r = 1; end
            T_MEM_WR:   mw = 1;
            T_BRANCH:   begin asa = 1; aop = 2'b01; pcc = 1; pcs = 1; end
            T_HALT:     hlt = 1;
            default: ;
        endcase
        return {pcw, pcc, pcs, irw, rd, rw, m2r, mr, mw, asa, asb, aop,
                hlt, exp_ill, exp_to, exp_ret};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [VW-1:0] a,
                       input logic [VW-1:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s #%0d: got %h expected %h (t=%0t)", nm, idx, a, e, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            chk("ctrl", e.n, act, e.v);
        end
    end

    // Advance one clock and queue the outputs expected in state s
    task automatic step(input tst_e s);
        sb_t e;
        @(posedge Clock);
        #1;
        if (s == T_FETCH && (prev_s == T_R_WB || prev_s == T_I_WB || prev_s == T_LW_WB ||
                             prev_s == T_MEM_WR || prev_s == T_BRANCH))
            exp_ret = exp_ret + 1'b1;
        prev_s = s;
        e.v = exp_vec(s);
        e.n = n_step++;
        sb.push_back(e);
    endtask

    // Asserted between edges so it also exercises the asynchronous path
    task automatic do_reset(input string nm);
        @(negedge Clock);
        #2;
        Reset = 1'b1;
        exp_ret = '0;
        exp_ill = 1'b0;
        exp_to = 1'b0;
        prev_s = T_IDLE;
        #1;
        chk(nm, 0, act, exp_vec(T_IDLE));
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    task automatic start();
        Run = 1'b1;
        step(T_FETCH);
    endtask

    task automatic instr_addi();
        opcode = 4'b0100;
        step(T_DECODE); step(T_I_EXEC); step(T_I_WB); step(T_FETCH);
    endtask

    initial begin
        #12;
        chk("reset", 0, act, exp_vec(T_IDLE));
        Reset = 1'b0;
        step(T_IDLE); step(T_IDLE);

        // R-type; Run dropped mid-instruction must not matter
        opcode = 4'b0000;
        start();
        Run = 1'b0;
        step(T_DECODE); step(T_R_EXEC); step(T_R_WB); step(T_FETCH);

        instr_addi();

        // LW: three wait cycles then ready
        opcode = 4'b1000;
        MemReady = 1'b0;
        step(T_DECODE); step(T_MEM_ADDR);
        step(T_MEM_RD); step(T_MEM_RD); step(T_MEM_RD); step(T_MEM_RD);
        MemReady = 1'b1;
        step(T_LW_WB);
        MemReady = 1'b0;
        step(T_FETCH);

        // SW zero-wait
        opcode = 4'b1100;
        step(T_DECODE); step(T_MEM_ADDR); step(T_MEM_WR);
        MemReady = 1'b1;
        step(T_FETCH);
        MemReady = 1'b0;

        // LW ready on the last permitted cycle: completes instead of timing out
        opcode = 4'b1000;
        step(T_DECODE); step(T_MEM_ADDR);
        for (int i = 0; i < 15; i++) step(T_MEM_RD);
        MemReady = 1'b1;
        step(T_LW_WB);
        MemReady = 1'b0;
        step(T_FETCH);

        // BEQ
        opcode = 4'b0010;
        step(T_DECODE); step(T_BRANCH); step(T_FETCH);

        // SW with MemReady stuck low: timeout after 15 wait cycles
        opcode = 4'b1100;
        step(T_DECODE); step(T_MEM_ADDR);
        for (int i = 0; i < 15; i++) step(T_MEM_WR);
        exp_to = 1'b1;
        step(T_HALT);
        Run = 1'b0; step(T_HALT);
        Run = 1'b1; step(T_HALT);
        do_reset("reset_after_timeout");

        // Illegal opcode; Run toggling in HALT is ignored
        opcode = 4'b0111;
        start();
        step(T_DECODE);
        exp_ill = 1'b1;
        step(T_HALT);
        Run = 1'b0; step(T_HALT);
        Run = 1'b1; step(T_HALT);
        Run = 1'b0; step(T_HALT);
        do_reset("reset_after_illegal");
        step(T_IDLE);

        // HALT opcode: halts without Illegal
        opcode = 4'b1111;
        start();
        step(T_DECODE); step(T_HALT); step(T_HALT);
        do_reset("reset_after_halt_op");

        // Counter wrap: 2**CW ADDIs return the count to zero
        start();
        for (int i = 0; i < (1 << CW); i++) instr_addi();

        // Reset in the middle of R_EXEC
        opcode = 4'b0000;
        step(T_DECODE); step(T_R_EXEC);
        do_reset("reset_mid_rexec");
        Run = 1'b0;
        step(T_IDLE);

        repeat (2) @(posedge Clock);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Moore-style sequencer for the multi-cycle variant of the 16-bit processor datapath. It breaks each instruction into FETCH/DECODE/EXEC/MEM/WB steps and drives every mux select, write enable and ALUOp of the datapath. It decodes the 4-bit opcode from the instruction register and waits on a data-memory ready handshake. It sits beside the datapath, replacing the single-cycle combinational control unit.

Parameters:
MAX_WAIT, 15, maximum cycles a MEM_RD/MEM_WR state waits for MemReady before a timeout halt.
CNT_W, 16, width of the retired-instruction counter.

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high; returns the FSM to IDLE.
Run  input  1  level; leaving IDLE to FETCH requires Run=1, sampled in IDLE only.
opcode  input  4  instruction[15:12] from the IR, valid from DECODE onward.
MemReady  input  1  data memory completed the access this cycle.
PCWrite  output  1  unconditional PC load.
PCWriteCond  output  1  PC load qualified by datapath zero flag (BEQ).
PCSource  output  1  0 = ALU result (PC+2), 1 = ALUOut (branch target).
IRWrite  output  1  latch instruction into IR.
RegDst  output  1  0 = rt [9:8], 1 = rd [7:6].
RegWrite  output  1  register-file write enable.
MemToReg  output  1  0 = ALUOut, 1 = MDR.
MemRead  output  1  data-memory read strobe.
MemWrite  output  1  data-memory write strobe.
ALUSrcA  output  1  0 = PC, 1 = readData1.
ALUSrcB  output  2  00 = readData2, 01 = const 2, 10 = sign-ext imm8, 11 = sign-ext imm8 << 1.
ALUOp  output  2  00 = add, 01 = sub (compare), 10 = use funct.
Halted  output  1  FSM is in HALT.
Illegal  output  1  sticky; HALT entered on an undefined opcode.
MemTimeout  output  1  sticky; HALT entered on a MemReady timeout.
RetiredCount  output  CNT_W  instructions completed since reset.

Behaviour:
- Reset, asynchronous: state=IDLE, every control output 0, ALUSrcB/ALUOp=00, Halted/Illegal/MemTimeout=0, RetiredCount=0, wait counter=0.
- All controls are decoded from state only (Moore). Any control not listed for a state is 0.
- Opcode map: 0000 R-type, 0100 ADDI, 1000 LW, 1100 SW, 0010 BEQ, 1111 HALT. All others are illegal.
- IDLE: no controls asserted. Goes to FETCH when Run=1, else stays in IDLE.
- FETCH: IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=0. Goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - R-type -> R_EXEC
  - ADDI -> I_EXEC
  - LW/SW -> MEM_ADDR
  - BEQ -> BRANCH
  - HALT -> HALT
  - illegal -> HALT and set Illegal.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to R_WB.
- R_WB: RegDst=1, RegWrite=1, MemToReg=0. Goes to FETCH and retires.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to I_WB.
- I_WB: RegDst=0, RegWrite=1, MemToReg=0. Goes to FETCH and retires.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW goes to MEM_RD, SW goes to MEM_WR.
- MEM_RD: MemRead=1 held while waiting. On MemReady=1 goes to LW_WB.
- LW_WB: RegDst=0, RegWrite=1, MemToReg=1. Goes to FETCH and retires.
- MEM_WR: MemWrite=1 held while waiting. On MemReady=1 goes to FETCH and retires.
- Wait counter: cleared on entry to MEM_RD/MEM_WR, increments each cycle MemReady=0. When the counter reaches MAX_WAIT with MemReady still 0, goes to HALT and sets MemTimeout. MemReady=1 in that same cycle wins: the access completes normally. Zero-wait access (MemReady=1 on the first cycle) is legal: 1 cycle in the MEM state.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. Goes to FETCH and retires.
- HALT: Halted=1, no write enables. Stays in HALT until Reset; Run is ignored.
- Retire: RetiredCount increments by 1 on each transition into FETCH from R_WB, I_WB, LW_WB, MEM_WR or BRANCH. Wraps 0xFFFF -> 0. HALT and illegal opcodes do not retire.
- Run deasserted mid-instruction has no effect; the FSM returns to IDLE only via Reset.
- Latency, cycles per instruction (including FETCH):
  - R-type, ADDI: 4
  - BEQ: 3
  - SW: 4 + waits
  - LW: 5 + waits
- Reset mid-instruction aborts it immediately; no partial RegWrite/MemWrite is asserted after Reset rises.

Test Plan:
- Reset then Run=1, opcode=0000 -> states FETCH, DECODE, R_EXEC, R_WB; R_WB asserts RegDst=1 and RegWrite=1; RetiredCount=1 after 4 cycles.
- LW (1000), MemReady low 3 cycles then high -> MemRead=1 for exactly 4 cycles; LW_WB asserts MemToReg=1; total 8 cycles; RetiredCount +1.
- SW (1100), MemReady stuck 0, MAX_WAIT=15 -> HALT after 15 wait cycles; MemTimeout=1, Halted=1, MemWrite=0 in HALT; RetiredCount unchanged.
- BEQ (0010) -> BRANCH asserts PCWriteCond=1, PCSource=1, ALUOp=01; back in FETCH after 3 cycles.
- opcode=0111 -> HALT from DECODE with Illegal=1; toggling Run has no effect; Reset clears Illegal/Halted and returns to IDLE.
- Preload RetiredCount near 0xFFFF via 65535 ADDI instructions, execute one more -> count wraps to 0x0000; Reset asserted mid-R_EXEC -> all outputs 0 asynchronously.
